// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU for the operand/instruction source to
// writeback path, with backpressure on both sides.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> opcode 0010 runs a WIDTH-cycle shift-add multiplier (MULT state)
//   undefined -> no multiplier logic; 0010 is reported as an illegal opcode
//
// Parameters:
//   WIDTH         operand/result width (>= 2); SHW = $clog2(WIDTH) is derived
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operand/instruction transfer request
//   in_ready      block can accept a transfer this cycle
//   data0         operand A
//   data1         operand B; data1[SHW-1:0] is the shift amount for shifts
//   instruction   4-bit opcode
//   out_valid     result/flags valid
//   out_ready     consumer accepts the result
//   result        registered result
//   carry_flag    registered carry / borrow / overflow / last bit shifted out
//   zero_flag     registered (result == 0)
//   illegal_flag  registered; opcode was not a legal operation
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [3:0]       instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             illegal_flag
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_SHL  = 4'b0000;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1101;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b0010;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, MULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

  state_t state, state_next;

  logic             accept;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_illegal;
  logic             is_mul;

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             illegal_q;

`ifdef ALU_MUL_EN
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [CW-1:0]      mul_cnt;
  logic               mul_done;
`endif

  // Shift amount is reduced modulo WIDTH so non-power-of-two widths behave.
  // The one-bit extensions catch the last bit shifted out: for SHL it lands
  // in bit WIDTH, for SHR in bit 0; with amt = 0 both positions hold 0.
  assign amt     = SHW'(32'(data1[SHW-1:0]) % WIDTH);
  assign shl_ext = {1'b0, data0} << amt;
  assign shr_ext = {data0, 1'b0} >> amt;
  assign add_ext = {1'b0, data0} + {1'b0, data1};
  // Bit WIDTH of the extended difference is the borrow, i.e. A < B.
  assign sub_ext = {1'b0, data0} - {1'b0, data1};

  always_comb begin
    alu_result  = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    is_mul      = 1'b0;
    case (instruction)
      OP_SHL:  begin alu_result = shl_ext[WIDTH-1:0]; alu_carry = shl_ext[WIDTH]; end
      OP_SHR:  begin alu_result = shr_ext[WIDTH:1];   alu_carry = shr_ext[0];     end
      OP_ADD:  begin alu_result = add_ext[WIDTH-1:0]; alu_carry = add_ext[WIDTH]; end
      OP_SUB:  begin alu_result = sub_ext[WIDTH-1:0]; alu_carry = sub_ext[WIDTH]; end
      OP_AND:  alu_result = data0 & data1;
      OP_OR:   alu_result = data0 | data1;
      OP_XOR:  alu_result = data0 ^ data1;
      OP_NAND: alu_result = ~(data0 & data1);
`ifdef ALU_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          state_next = is_mul ? MULT : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      MULT: if (mul_done) state_next = DONE;
`endif
      DONE: begin
        // A new op may be accepted on the same edge the old result leaves.
        if (out_ready) begin
          if (in_valid) begin
`ifdef ALU_MUL_EN
            state_next = is_mul ? MULT : DONE;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ALU_MUL_EN
  // One shift-add step per cycle: add the shifted multiplicand when the
  // current multiplier LSB is set. The last step is forwarded straight into
  // the result registers so out_valid rises WIDTH edges after acceptance.
  assign mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
  assign mul_done     = (state == MULT) && (mul_cnt == MUL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (accept && is_mul) begin
      mul_acc    <= '0;
      mul_mcand  <= {{WIDTH{1'b0}}, data0};
      mul_mplier <= data1;
      mul_cnt    <= '0;
    end else if (state == MULT) begin
      mul_acc    <= mul_acc_next;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + CW'(1);
    end
  end
`endif

  // Result and flags only change on an accepting edge (single-cycle ops) or
  // on the final multiply step, so they hold steady while out_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q  <= alu_result;
      carry_q   <= alu_carry;
      zero_q    <= (alu_result == '0);
      illegal_q <= alu_illegal;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      result_q  <= mul_acc_next[WIDTH-1:0];
      carry_q   <= |mul_acc_next[2*WIDTH-1:WIDTH];
      zero_q    <= (mul_acc_next[WIDTH-1:0] == '0);
      illegal_q <= 1'b0;
    end
`endif
  end

  assign result       = result_q;
  assign carry_flag   = carry_q;
  assign zero_flag    = zero_q;
  assign illegal_flag = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed testbench for alu_pipe at WIDTH = 8.
// Each task drives one scenario and compares outputs against hand-computed
// constants. Multiplier scenarios are selected by ALU_MUL_EN, matching the DUT.
module tb_alu_pipe;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [3:0] instruction;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_flag;
  logic       zero_flag;
  logic       illegal_flag;

  int n_cmp;
  int n_bad;

  alu_pipe #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data0        (data0),
    .data1        (data1),
    .instruction  (instruction),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
    .illegal_flag (illegal_flag)
  );

  // Clock is gated so reset can be checked with no clock running.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Present one op at the falling edge, let it be accepted on the next
  // rising edge, then drop in_valid; outputs are sampled 1 time unit later.
  task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    instruction = op;
    data0       = a;
    data1       = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b1)     begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)    begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 8'd0)       begin n_bad++; $display("[TB] FAIL reset_result: got %0d want 0", result); end
    n_cmp++; if (carry_flag !== 1'b0)   begin n_bad++; $display("[TB] FAIL reset_carry: got %b want 0", carry_flag); end
    n_cmp++; if (zero_flag !== 1'b0)    begin n_bad++; $display("[TB] FAIL reset_zero: got %b want 0", zero_flag); end
    n_cmp++; if (illegal_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_illegal: got %b want 0", illegal_flag); end
    #2;
    rst_n  = 1'b1;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_arith();
    apply_stimulus(4'b1000, 8'd200, 8'd100);
    n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("[TB] FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'd44)    begin n_bad++; $display("[TB] FAIL add_result: got %0d want 44", result); end
    n_cmp++; if (carry_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL add_carry: got %b want 1", carry_flag); end
    n_cmp++; if (zero_flag !== 1'b0)  begin n_bad++; $display("[TB] FAIL add_zero: got %b want 0", zero_flag); end
    apply_stimulus(4'b1100, 8'd50, 8'd100);
    n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("[TB] FAIL sub_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'd206)   begin n_bad++; $display("[TB] FAIL sub_result: got %0d want 206", result); end
    n_cmp++; if (carry_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL sub_borrow: got %b want 1", carry_flag); end
    apply_stimulus(4'b1100, 8'd100, 8'd100);
    n_cmp++; if (result !== 8'd0)     begin n_bad++; $display("[TB] FAIL sub_eq_result: got %0d want 0", result); end
    n_cmp++; if (carry_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL sub_eq_borrow: got %b want 0", carry_flag); end
    n_cmp++; if (zero_flag !== 1'b1)  begin n_bad++; $display("[TB] FAIL sub_eq_zero: got %b want 1", zero_flag); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("[TB] FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_shift_logic();
    apply_stimulus(4'b0000, 8'h81, 8'd1);
    n_cmp++; if (result !== 8'h02)    begin n_bad++; $display("[TB] FAIL shl1_result: got %h want 02", result); end
    n_cmp++; if (carry_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL shl1_carry: got %b want 1", carry_flag); end
    apply_stimulus(4'b0100, 8'h81, 8'd3);
    n_cmp++; if (result !== 8'h10)    begin n_bad++; $display("[TB] FAIL shr3_result: got %h want 10", result); end
    n_cmp++; if (carry_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL shr3_carry: got %b want 0", carry_flag); end
    apply_stimulus(4'b0100, 8'h84, 8'd3);
    n_cmp++; if (result !== 8'h10)    begin n_bad++; $display("[TB] FAIL shr3b_result: got %h want 10", result); end
    n_cmp++; if (carry_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL shr3b_carry: got %b want 1", carry_flag); end
    apply_stimulus(4'b0000, 8'd100, 8'd0);
    n_cmp++; if (result !== 8'd100)   begin n_bad++; $display("[TB] FAIL shl0_result: got %0d want 100", result); end
    n_cmp++; if (carry_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL shl0_carry: got %b want 0", carry_flag); end
    // Only data1[2:0] is the amount: 0x09 shifts by 1.
    apply_stimulus(4'b0000, 8'h81, 8'h09);
    n_cmp++; if (result !== 8'h02)    begin n_bad++; $display("[TB] FAIL shl_mod_result: got %h want 02", result); end
    n_cmp++; if (carry_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL shl_mod_carry: got %b want 1", carry_flag); end
    apply_stimulus(4'b0001, 8'hF0, 8'h0F);
    n_cmp++; if (result !== 8'h00)    begin n_bad++; $display("[TB] FAIL and_result: got %h want 00", result); end
    n_cmp++; if (zero_flag !== 1'b1)  begin n_bad++; $display("[TB] FAIL and_zero: got %b want 1", zero_flag); end
    apply_stimulus(4'b1101, 8'hFF, 8'hFF);
    n_cmp++; if (result !== 8'h00)    begin n_bad++; $display("[TB] FAIL nand_result: got %h want 00", result); end
    n_cmp++; if (zero_flag !== 1'b1)  begin n_bad++; $display("[TB] FAIL nand_zero: got %b want 1", zero_flag); end
    apply_stimulus(4'b0101, 8'h0C, 8'h30);
    n_cmp++; if (result !== 8'h3C)    begin n_bad++; $display("[TB] FAIL or_result: got %h want 3C", result); end
    n_cmp++; if (zero_flag !== 1'b0)  begin n_bad++; $display("[TB] FAIL or_zero: got %b want 0", zero_flag); end
  endtask

  task automatic test_illegal();
    apply_stimulus(4'b1111, 8'h12, 8'h34);
    n_cmp++; if (out_valid !== 1'b1)    begin n_bad++; $display("[TB] FAIL ill_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'h00)      begin n_bad++; $display("[TB] FAIL ill_result: got %h want 00", result); end
    n_cmp++; if (carry_flag !== 1'b0)   begin n_bad++; $display("[TB] FAIL ill_carry: got %b want 0", carry_flag); end
    n_cmp++; if (zero_flag !== 1'b1)    begin n_bad++; $display("[TB] FAIL ill_zero: got %b want 1", zero_flag); end
    n_cmp++; if (illegal_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL ill_flag: got %b want 1", illegal_flag); end
    apply_stimulus(4'b1000, 8'd1, 8'd1);
    n_cmp++; if (result !== 8'd2)       begin n_bad++; $display("[TB] FAIL ill_next_result: got %0d want 2", result); end
    n_cmp++; if (illegal_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL ill_next_flag: got %b want 0", illegal_flag); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    apply_stimulus(4'b0010, 8'd20, 8'd13);
    // Edge N has passed; out_valid must rise only after edge N+8.
    for (int i = 1; i <= 8; i++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mul_early_valid cycle %0d: got %b want 0", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("[TB] FAIL mul_busy_ready cycle %0d: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("[TB] FAIL mul_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'd4)     begin n_bad++; $display("[TB] FAIL mul_result: got %0d want 4", result); end
    n_cmp++; if (carry_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL mul_ovf: got %b want 1", carry_flag); end
    apply_stimulus(4'b0010, 8'd15, 8'd17);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("[TB] FAIL mul2_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'd255)   begin n_bad++; $display("[TB] FAIL mul2_result: got %0d want 255", result); end
    n_cmp++; if (carry_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL mul2_ovf: got %b want 0", carry_flag); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_reset();
    apply_stimulus(4'b0010, 8'd20, 8'd13);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mulrst_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("[TB] FAIL mulrst_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mulrst_ghost cycle %0d: got %b want 0", i, out_valid); end
    end
  endtask
`else
  task automatic test_mul_disabled();
    apply_stimulus(4'b0010, 8'd20, 8'd13);
    n_cmp++; if (out_valid !== 1'b1)    begin n_bad++; $display("[TB] FAIL nomul_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'd0)       begin n_bad++; $display("[TB] FAIL nomul_result: got %0d want 0", result); end
    n_cmp++; if (carry_flag !== 1'b0)   begin n_bad++; $display("[TB] FAIL nomul_carry: got %b want 0", carry_flag); end
    n_cmp++; if (zero_flag !== 1'b1)    begin n_bad++; $display("[TB] FAIL nomul_zero: got %b want 1", zero_flag); end
    n_cmp++; if (illegal_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL nomul_flag: got %b want 1", illegal_flag); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0;
    apply_stimulus(4'b1000, 8'd1, 8'd2);
    n_cmp++; if (result !== 8'd3) begin n_bad++; $display("[TB] FAIL bp_first: got %0d want 3", result); end
    // A competing request while stalled must be neither accepted nor sampled.
    instruction = 4'b1000;
    data0       = 8'd9;
    data1       = 8'd9;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (result !== 8'd3)    begin n_bad++; $display("[TB] FAIL bp_hold_result cycle %0d: got %0d want 3", i, result); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_hold_valid cycle %0d: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("[TB] FAIL bp_hold_ready cycle %0d: got %b want 0", i, in_ready); end
    end
    @(negedge clk);
    instruction = 4'b1001;
    data0       = 8'hAA;
    data1       = 8'h55;
    out_ready   = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("[TB] FAIL b2b_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 8'hFF)    begin n_bad++; $display("[TB] FAIL b2b_result: got %h want FF", result); end
    n_cmp++; if (carry_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_carry: got %b want 0", carry_flag); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("[TB] FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    clk_en      = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    data0       = '0;
    data1       = '0;
    instruction = '0;
    test_reset();
    test_arith();
    test_shift_logic();
    test_illegal();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 8-bit combinational ALU. It accepts one operation per valid/ready transfer and registers the result and flags. It adds variable shift amounts, an illegal-opcode flag, and an optional multi-cycle shift-add multiplier. It sits between the operand/instruction source and the writeback stage, with backpressure on both sides.

## Interface
- WIDTH, 8, operand and result width; must be at least 2. SHW = $clog2(WIDTH) is derived, not overridable.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/instruction transfer request.
- in_ready  out  1  block can accept a transfer this cycle.
- data0  in  WIDTH  operand A.
- data1  in  WIDTH  operand B; for shifts, data1[SHW-1:0] is the shift amount.
- instruction  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- carry_flag  out  1  registered carry/borrow/overflow.
- zero_flag  out  1  registered (result == 0).
- illegal_flag  out  1  registered; opcode was not a legal operation.

## Operation
- Opcodes:
  - 0000 SHL: A << amt; carry = last bit shifted out.
  - 0100 SHR: logical A >> amt; carry = last bit shifted out.
  - For both shifts, amt = data1[SHW-1:0], taken modulo WIDTH. amt = 0 gives result A, carry 0.
  - 1000 ADD: carry = bit WIDTH of A+B.
  - 1100 SUB: A−B modulo 2^WIDTH; carry = 1 iff A < B (borrow).
  - 0001 AND, 0101 OR, 1001 XOR, 1101 NAND: carry 0.
  - 0010 MUL (see Configuration): result = low WIDTH bits of A*B; carry = OR of the high WIDTH bits (overflow).
  - All other opcodes: illegal. Result 0, carry 0, zero 1, illegal_flag 1.
- illegal_flag is 0 for every legal op. zero_flag is always (result == 0).
- FSM states:
  - IDLE: in_ready = 1.
  - MULT: in_ready = 0; one shift-add iteration per cycle with an iteration counter.
  - DONE: out_valid = 1; in_ready = out_ready.
- Transitions:
  - IDLE → DONE: accepted non-MUL op.
  - IDLE → MULT: accepted MUL op; operands latched.
  - MULT → DONE: after WIDTH iterations.
  - DONE → IDLE: out_ready = 1 and in_valid = 0.
  - DONE → DONE or DONE → MULT: out_ready = 1 and in_valid = 1. The new op is accepted on the same edge the old result is consumed.
  - DONE → DONE (hold): out_ready = 0. result and all flags stay stable.
- Operands are sampled only on the accepting edge. Input changes at other times have no effect.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, carry_flag 0, zero_flag 0, illegal_flag 0. The MUL counter and accumulator are cleared.
- Reset takes effect immediately and is independent of clk. An op in flight (MULT or DONE) is discarded with no output.
- Single-cycle ops: accepted on edge N; out_valid and result are visible after edge N.
- MUL: accepted on edge N; iterations run on edges N+1 through N+WIDTH. out_valid rises after edge N+WIDTH.
- Throughput: one single-cycle op per clock while out_ready is held high. MUL allows one op per WIDTH+1 cycles.
- in_ready is combinational from state and out_ready only; it never depends on in_valid.
- out_valid is never deasserted without a transfer (out_valid & out_ready).

## Configuration
- ALU_MUL_EN defined: MUL (0010) and the MULT state are compiled in.
- ALU_MUL_EN undefined: no multiplier logic and no MULT state. 0010 is treated as illegal (result 0, carry 0, zero 1, illegal_flag 1, latency 1).

## Test plan
All scenarios use WIDTH = 8 with out_ready = 1 unless stated.
- Reset: assert rst_n = 0 with no clock running → all outputs at reset values, in_ready = 1.
- Arithmetic:
  - ADD 200, 100 → result 44, carry 1, zero 0.
  - SUB 50, 100 → result 206, carry 1.
  - SUB 100, 100 → result 0, carry 0, zero 1.
  - Each out_valid appears one cycle after acceptance.
- Shifts and logic:
  - SHL 0x81 by 1 → 0x02, carry 1.
  - SHR 0x81 by 3 → 0x10, carry 0.
  - SHL 100 by 0 → 100, carry 0.
  - AND 0xF0, 0x0F → 0, zero 1.
  - NAND 0xFF, 0xFF → 0, zero 1.
- Illegal opcode: 1111 with any operands → result 0, zero 1, illegal_flag 1. The next legal op clears illegal_flag.
- MUL with ALU_MUL_EN:
  - 20 × 13 → result 4, carry 1, out_valid exactly 8 cycles after acceptance, in_ready 0 throughout.
  - 15 × 17 → result 255, carry 0.
  - Drive rst_n low at iteration 4 → no out_valid, back in IDLE.
- Backpressure: hold out_ready = 0 for 5 cycles after ADD 1, 2 → result 3 stable, in_ready 0. Raising out_ready together with in_valid (XOR 0xAA, 0x55) → next result 0xFF on the following cycle, no bubble.
